// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flip-flop does the arithmetic.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Full-subtractor cell, returns {borrow_out, difference_bit}
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bi);
    fs_cell = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  logic [1:0]       state_r, state_next_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, res_r, diff_r;
  logic [CW-1:0]    count_r;
  logic             br_r, a_msb_r, b_msb_r;
  logic             bout_r, ovf_r, busy_r, done_r;
  logic [1:0]       cell_s;
  logic             accept_s, last_s;

  // Next-state decode and the combinational subtractor cell
  always_comb begin
    cell_s       = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
    last_s       = (count_r == LAST_BIT);
    accept_s     = 1'b0;
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        accept_s     = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State, operand shifting and result transfer; outputs only move on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      count_r <= '0;
      br_r    <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == SHIFT);
      done_r  <= (state_next_s == DONE);
      if (accept_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        br_r    <= bin;
        res_r   <= '0;
        count_r <= '0;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
      end else if (state_r == SHIFT) begin
        a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
        br_r    <= cell_s[1];
        res_r   <= {cell_s[0], res_r[WIDTH-1:1]};
        count_r <= count_r + CW'(1);
        if (last_s) begin
          diff_r <= {cell_s[0], res_r[WIDTH-1:1]};
          bout_r <= cell_s[1];
          ovf_r  <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ cell_s[0]);
        end else begin
          diff_r <= diff_r;
        end
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor: an 8-bit instance for the main cases
// and a 2-bit instance swept exhaustively against an integer reference model.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start2, bin2, busy2, done2, bout2, ovf2;
  logic [1:0] a2, b2, diff2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_full_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done on the 8-bit instance; returns edges taken (99 on timeout)
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (done8 !== 1'b1) n = 99;
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    logic [7:0] held;
    @(negedge clk);
    a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
    held = diff8;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    check({tag, ".busy"}, {31'd0, busy8}, 32'd1);
    repeat (4) @(posedge clk);
    #1 check({tag, ".hold"}, {24'd0, diff8}, {24'd0, held});
    wait_done8(n);
    check({tag, ".lat"}, n + 4, 32'd8);
    check({tag, ".diff"}, {24'd0, diff8}, {24'd0, ed});
    check({tag, ".bout"}, {31'd0, bout8}, {31'd0, eb});
    check({tag, ".ovf"}, {31'd0, ovf8}, {31'd0, eo});
    check({tag, ".busy_done"}, {31'd0, busy8}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, done8}, 32'd0);
  endtask

  initial begin
    int n;
    int sa, sb, sd, ed, eb, eo;
    logic [1:0] held2;

    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; bin2 = 1'b0;
    #12;
    check("rst.busy", {31'd0, busy8}, 32'd0);
    check("rst.done", {31'd0, done8}, 32'd0);
    check("rst.diff", {24'd0, diff8}, 32'd0);
    check("rst.bout_ovf", {30'd0, bout8, ovf8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run8("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run8("borrow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run8("bin_eq", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Back-to-back with start held high
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    wait_done8(n);
    check("b2b.lat1", n, 32'd8);
    check("b2b.diff1", {24'd0, diff8}, 32'h0F);
    @(posedge clk); #1;
    check("b2b.rearm", {30'd0, busy8, done8}, 32'd2);
    wait_done8(n);
    check("b2b.period", n + 1, 32'd9);
    check("b2b.diff2", {24'd0, diff8}, 32'h0F);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b.stop", {30'd0, busy8, done8}, 32'd0);

    // Start pulse during SHIFT must be ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'h20; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(n);
    check("ign.lat", n + 3, 32'd8);
    check("ign.diff", {24'd0, diff8}, 32'h0F);
    @(posedge clk); #1;
    check("ign.idle", {30'd0, busy8, done8}, 32'd0);

    // Asynchronous reset during SHIFT
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.busy", {31'd0, busy8}, 32'd0);
    check("arst.diff", {24'd0, diff8}, 32'd0);
    check("arst.flags", {29'd0, done8, bout8, ovf8}, 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      check("arst.nodone", {31'd0, done8}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run8("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Exhaustive 2-bit sweep against an integer model
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ed = (ia - ib - ic) & 3;
          eb = (ia < ib + ic) ? 1 : 0;
          sa = (ia > 1) ? ia - 4 : ia;
          sb = (ib > 1) ? ib - 4 : ib;
          sd = sa - sb - ic;
          eo = (sd < -2 || sd > 1) ? 1 : 0;
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); bin2 = 1'(ic); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0;
          n = 0;
          while (done2 !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
          end
          check("x2.lat", n, 32'd2);
          check("x2.diff", {30'd0, diff2}, ed);
          check("x2.bout", {31'd0, bout2}, eb);
          check("x2.ovf", {31'd0, ovf2}, eo);
          held2 = diff2;
          repeat (2) @(posedge clk);
          #1 check("x2.idle_hold", {30'd0, diff2}, {30'd0, held2});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
